// File: rtl/memory_access.sv
// Memory stage of the 64-bit pipeline: resolves branches and runs one load/store
// per instruction over a req/ack data-memory bus, stalling the pipeline meanwhile.
module memory_access #(
   parameter int unsigned N       = 64,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         MemRead_M,
   input  logic         MemWrite_M,
   input  logic         Branch_M,
   input  logic         zero_M,
   input  logic [N-1:0] aluResult_M,
   input  logic [N-1:0] writeData_M,
   input  logic [N-1:0] PCBranch_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_F,
   output logic         stall_M,
   output logic [N-1:0] readData_M,
   output logic         mem_err,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [N-1:0]  addr_q, addr_d;
   logic [N-1:0]  wdata_q, wdata_d;
   logic [N-1:0]  rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic acc, mis;

   assign acc = MemRead_M | MemWrite_M;
   assign mis = acc & (aluResult_M[2:0] != 3'b000);

   // Branch resolution is purely combinational and independent of the memory FSM.
   assign PCSrc_M    = Branch_M & zero_M;
   assign PCBranch_F = PCBranch_M;

   // Stall while a transaction is being launched or is outstanding; DONE releases.
   assign stall_M = ((state_q == StIdle) & acc & ~mis) | (state_q == StReq);

   assign dm_req     = req_q;
   assign dm_we      = we_q;
   assign dm_addr    = addr_q;
   assign dm_wdata   = wdata_q;
   assign readData_M = rdata_q;
   assign mem_err    = err_q;

   // Next-state logic for the access FSM and its bus/result registers.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (mis) begin
               // Misaligned op retires as a nop; only the sticky error records it.
               err_d = 1'b1;
            end else if (acc) begin
               addr_d  = aluResult_M;
               wdata_d = writeData_M;
               we_d    = MemWrite_M;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (dm_ack) begin
               req_d = 1'b0;
               if (!we_q) rdata_d = dm_rdata;
               state_d = StDone;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               req_d = 1'b0;
               err_d = 1'b1;
               // A timed-out load returns zero; stores leave the load result alone.
               if (!we_q) rdata_d = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; async reset drops any in-flight request immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: comb vector table plus multi-cycle sequences.
module tb_memory_access;

   localparam int unsigned N       = 64;
   localparam int unsigned TIMEOUT = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         MemRead_M, MemWrite_M, Branch_M, zero_M;
   logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
   logic         PCSrc_M;
   logic [N-1:0] PCBranch_F;
   logic         stall_M;
   logic [N-1:0] readData_M;
   logic         mem_err;
   logic         dm_req, dm_we;
   logic [N-1:0] dm_addr, dm_wdata;
   logic         dm_ack;
   logic [N-1:0] dm_rdata;

   int checks = 0;
   int errors = 0;

   memory_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .MemRead_M   (MemRead_M),
      .MemWrite_M  (MemWrite_M),
      .Branch_M    (Branch_M),
      .zero_M      (zero_M),
      .aluResult_M (aluResult_M),
      .writeData_M (writeData_M),
      .PCBranch_M  (PCBranch_M),
      .PCSrc_M     (PCSrc_M),
      .PCBranch_F  (PCBranch_F),
      .stall_M     (stall_M),
      .readData_M  (readData_M),
      .mem_err     (mem_err),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_ack      (dm_ack),
      .dm_rdata    (dm_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         br, zr, rd, wr;
      logic [N-1:0] addr, target;
      logic         exp_pcsrc, exp_stall;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      MemRead_M = 0; MemWrite_M = 0; Branch_M = 0; zero_M = 0;
      aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
      dm_ack = 0; dm_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      step();
      reset = 0;
      step();
   endtask

   // Runs one aligned access from IDLE; returns in the DONE cycle (first stall_M=0 cycle).
   task automatic access(input string tag, input logic rd, input logic [N-1:0] addr,
                         input logic [N-1:0] wd, input int ack_at, input logic [N-1:0] rv,
                         output int stalls, output int reqs);
      bit done = 0;
      MemRead_M = rd; MemWrite_M = ~rd; aluResult_M = addr; writeData_M = wd;
      stalls = 0; reqs = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         dm_ack = 0;
         if (dm_req) begin
            reqs++;
            check({tag, " dm_addr"}, dm_addr, addr);
            check({tag, " dm_we"}, {63'b0, dm_we}, {63'b0, ~rd});
            if (!rd) check({tag, " dm_wdata"}, dm_wdata, wd);
            if (reqs == ack_at) begin
               dm_ack = 1;
               dm_rdata = rv;
            end
         end
         #1;
         if (stall_M) begin
            stalls++;
            step();
         end else begin
            done = 1;
         end
      end
      dm_ack = 0;
      check({tag, " completed within bound"}, {63'b0, done}, 64'd1);
   endtask

   int st, rq;

   initial begin
      vecs[0] = '{"br taken",      1, 1, 0, 0, 64'h0,   64'h1000, 1, 0};
      vecs[1] = '{"br not taken",  1, 0, 0, 0, 64'h0,   64'h2000, 0, 0};
      vecs[2] = '{"no br zero",    0, 1, 0, 0, 64'h0,   64'h3004, 0, 0};
      vecs[3] = '{"aligned load",  0, 0, 1, 0, 64'h40,  64'h0,    0, 1};
      vecs[4] = '{"mis store",     0, 0, 0, 1, 64'h103, 64'h0,    0, 0};
      vecs[5] = '{"mis load+br",   1, 1, 1, 0, 64'h7,   64'hABC,  1, 0};

      reset = 1;
      clear_inputs();
      #12;
      // Reset state
      check("reset dm_req", {63'b0, dm_req}, 64'd0);
      check("reset stall", {63'b0, stall_M}, 64'd0);
      check("reset readData", readData_M, 64'd0);
      check("reset mem_err", {63'b0, mem_err}, 64'd0);
      check("reset dm_addr", dm_addr, 64'd0);
      reset = 0;
      step();

      // Combinational table, inputs withdrawn before any clock edge
      foreach (vecs[i]) begin
         Branch_M = vecs[i].br; zero_M = vecs[i].zr;
         MemRead_M = vecs[i].rd; MemWrite_M = vecs[i].wr;
         aluResult_M = vecs[i].addr; PCBranch_M = vecs[i].target;
         #1;
         check({vecs[i].name, " PCSrc"}, {63'b0, PCSrc_M}, {63'b0, vecs[i].exp_pcsrc});
         check({vecs[i].name, " PCBranch_F"}, PCBranch_F, vecs[i].target);
         check({vecs[i].name, " stall"}, {63'b0, stall_M}, {63'b0, vecs[i].exp_stall});
         clear_inputs();
         step();
      end
      check("table no err", {63'b0, mem_err}, 64'd0);

      // Load with ack on 3rd REQ cycle
      access("load1", 1, 64'h100, 64'h0, 3, 64'hDEADBEEF, st, rq);
      check("load1 stalls", st, 4);
      check("load1 reqs", rq, 3);
      check("load1 readData", readData_M, 64'hDEADBEEF);
      check("load1 req low", {63'b0, dm_req}, 64'd0);
      step(); clear_inputs();

      // Store with immediate ack
      access("store", 0, 64'h208, 64'h55, 1, 64'h1234, st, rq);
      check("store stalls", st, 2);
      check("store reqs", rq, 1);
      check("store readData kept", readData_M, 64'hDEADBEEF);
      step(); clear_inputs();

      // Back-to-back loads
      access("b2b0", 1, 64'h0, 64'h0, 1, 64'h11, st, rq);
      check("b2b0 stalls", st, 2);
      check("b2b0 readData", readData_M, 64'h11);
      step();
      access("b2b1", 1, 64'h8, 64'h0, 1, 64'h22, st, rq);
      check("b2b1 stalls", st, 2);
      check("b2b1 readData", readData_M, 64'h22);
      step(); clear_inputs();

      // Load timeout
      access("tmo", 1, 64'h300, 64'h0, 0, 64'h0, st, rq);
      check("tmo reqs", rq, 4);
      check("tmo stalls", st, 5);
      check("tmo mem_err", {63'b0, mem_err}, 64'd1);
      check("tmo readData", readData_M, 64'd0);
      step(); clear_inputs();
      step();
      check("tmo mem_err sticky", {63'b0, mem_err}, 64'd1);

      // Misaligned store
      do_reset();
      MemWrite_M = 1; aluResult_M = 64'h103; writeData_M = 64'h99;
      #1;
      check("mis stall", {63'b0, stall_M}, 64'd0);
      step();
      check("mis mem_err", {63'b0, mem_err}, 64'd1);
      check("mis no req", {63'b0, dm_req}, 64'd0);
      clear_inputs();
      step();
      check("mis no req later", {63'b0, dm_req}, 64'd0);

      // Reset in 2nd REQ cycle, late ack ignored
      do_reset();
      MemRead_M = 1; aluResult_M = 64'h80;
      step();
      check("rst req1", {63'b0, dm_req}, 64'd1);
      step();
      check("rst req2", {63'b0, dm_req}, 64'd1);
      reset = 1;
      #1;
      check("rst req drop", {63'b0, dm_req}, 64'd0);
      clear_inputs();
      step();
      reset = 0;
      dm_ack = 1; dm_rdata = 64'hBAD;
      step();
      dm_ack = 0;
      check("rst late ack readData", readData_M, 64'd0);
      check("rst late ack req", {63'b0, dm_req}, 64'd0);
      check("rst late ack stall", {63'b0, stall_M}, 64'd0);
      check("rst no err", {63'b0, mem_err}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global timeout");
      $fatal(1);
   end

endmodule
